// File: rtl/stack_ctrl_sequencer.sv
// Control sequencer for the stack/TOS datapath: expands one accepted stack request into
// timed register-enable, mux-select and write strobes, and tracks the stack depth.
module stack_ctrl_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [2:0]            req_src,
  input  logic [ADDR_WIDTH-1:0] tos_restore,
  output logic                  req_ready,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic [2:0]            sel_mux_stack,
  output logic                  ctrl_reg_write_stack,
  output logic                  ctrl_stack,
  output logic                  ctrl_reg_read_stack,
  output logic                  ctrl_reg_read_mem,
  output logic                  ctrl_reg_write_mem,
  output logic                  ctrl_mem_ext,
  output logic                  ctrl_reg_tos,
  output logic                  sel_tos_updater,
  output logic                  sel_mux_tos
);

  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(STACK_DEPTH);

  localparam logic [2:0] OP_PUSH    = 3'b000;
  localparam logic [2:0] OP_POP     = 3'b001;
  localparam logic [2:0] OP_LOAD    = 3'b010;
  localparam logic [2:0] OP_STORE   = 3'b011;
  localparam logic [2:0] OP_RESTORE = 3'b100;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_P_LATCH = 4'd1;
  localparam logic [3:0] S_P_WR    = 4'd2;
  localparam logic [3:0] S_P_INC   = 4'd3;
  localparam logic [3:0] S_D_DEC   = 4'd4;
  localparam logic [3:0] S_D_WAIT  = 4'd5;
  localparam logic [3:0] S_D_RD    = 4'd6;
  localparam logic [3:0] S_L_WAIT  = 4'd7;
  localparam logic [3:0] S_L_RD    = 4'd8;
  localparam logic [3:0] S_S_WREG  = 4'd9;
  localparam logic [3:0] S_S_WEXT  = 4'd10;
  localparam logic [3:0] S_T_LD    = 4'd11;
  localparam logic [3:0] S_ERR     = 4'd12;
  localparam logic [3:0] S_DONE    = 4'd13;

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] depth_q, restore_q, restore_sat;
  logic [2:0]            src_q;
  logic                  store_q, ovf_q, unf_q;
  logic                  accept, is_full, is_empty;

  assign accept      = (state_q == S_IDLE) && req_valid;
  assign is_full     = (depth_q == FULL);
  assign is_empty    = (depth_q == '0);
  assign restore_sat = (restore_q > FULL) ? FULL : restore_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_PUSH:    state_d = is_full ? S_ERR : S_P_LATCH;
            OP_LOAD:    state_d = is_full ? S_ERR : S_L_WAIT;
            OP_POP,
            OP_STORE:   state_d = is_empty ? S_ERR : S_D_DEC;
            OP_RESTORE: state_d = S_T_LD;
            default:    state_d = S_DONE;
          endcase
        end
      end
      S_P_LATCH: state_d = S_P_WR;
      S_P_WR:    state_d = S_P_INC;
      S_P_INC:   state_d = S_DONE;
      S_D_DEC:   state_d = S_D_WAIT;
      S_D_WAIT:  state_d = S_D_RD;
      S_D_RD:    state_d = store_q ? S_S_WREG : S_DONE;
      S_L_WAIT:  state_d = S_L_RD;
      S_L_RD:    state_d = S_P_LATCH;
      S_S_WREG:  state_d = S_S_WEXT;
      S_S_WEXT:  state_d = S_DONE;
      S_T_LD:    state_d = S_DONE;
      S_ERR:     state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      depth_q   <= '0;
      restore_q <= '0;
      src_q     <= 3'b000;
      store_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // LOAD pushes the external-memory read register, always mux source 1.
        src_q     <= (req_op == OP_LOAD) ? 3'b001 : req_src;
        restore_q <= tos_restore;
        store_q   <= (req_op == OP_STORE);
        ovf_q     <= ((req_op == OP_PUSH) || (req_op == OP_LOAD)) && is_full;
        unf_q     <= ((req_op == OP_POP) || (req_op == OP_STORE)) && is_empty;
      end
      unique case (state_q)
        S_P_INC: depth_q <= depth_q + 1'b1;
        S_D_DEC: depth_q <= depth_q - 1'b1;
        S_T_LD:  depth_q <= restore_sat;
        default: depth_q <= depth_q;
      endcase
    end
  end

  always_comb begin
    req_ready            = (state_q == S_IDLE);
    done                 = (state_q == S_DONE);
    err_overflow         = (state_q == S_DONE) && ovf_q;
    err_underflow        = (state_q == S_DONE) && unf_q;
    sel_mux_stack        = 3'b000;
    ctrl_reg_write_stack = 1'b0;
    ctrl_stack           = 1'b0;
    ctrl_reg_read_stack  = 1'b0;
    ctrl_reg_read_mem    = 1'b0;
    ctrl_reg_write_mem   = 1'b0;
    ctrl_mem_ext         = 1'b0;
    ctrl_reg_tos         = 1'b0;
    sel_tos_updater      = 1'b0;
    sel_mux_tos          = 1'b0;
    unique case (state_q)
      S_P_LATCH: begin
        sel_mux_stack        = src_q;
        ctrl_reg_write_stack = 1'b1;
      end
      S_P_WR: begin
        sel_mux_stack = src_q;
        ctrl_stack    = 1'b1;
      end
      S_P_INC: begin
        sel_mux_stack   = src_q;
        ctrl_reg_tos    = 1'b1;
        sel_tos_updater = 1'b1;
      end
      S_D_DEC:  ctrl_reg_tos        = 1'b1;
      S_D_RD:   ctrl_reg_read_stack = 1'b1;
      S_L_RD:   ctrl_reg_read_mem   = 1'b1;
      S_S_WREG: ctrl_reg_write_mem  = 1'b1;
      S_S_WEXT: ctrl_mem_ext        = 1'b1;
      S_T_LD: begin
        sel_mux_tos  = 1'b1;
        ctrl_reg_tos = 1'b1;
      end
      default: ;
    endcase
  end

  assign depth = depth_q;

endmodule

// File: tb/tb_stack_ctrl_sequencer.sv
// Bench for stack_ctrl_sequencer: a transaction-level model expands each accepted request into
// the expected per-cycle output words, compared against the DUT every cycle.
module tb_stack_ctrl_sequencer;

  localparam int AW   = 4;
  localparam int FULL = 6;

  typedef struct packed {
    logic       ready, dn, eo, eu;
    logic [2:0] sel;
    logic       wstk, stk, rstk, rmem, wmem, mext, tos, upd, mtos;
  } out_t;

  typedef struct {
    out_t o;
    int   d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [2:0]    req_op = 3'b000;
  logic [2:0]    req_src = 3'b000;
  logic [AW-1:0] tos_restore = '0;
  logic          req_ready, done, err_overflow, err_underflow;
  logic [AW-1:0] depth;
  logic [2:0]    sel_mux_stack;
  logic          ctrl_reg_write_stack, ctrl_stack, ctrl_reg_read_stack, ctrl_reg_read_mem;
  logic          ctrl_reg_write_mem, ctrl_mem_ext, ctrl_reg_tos, sel_tos_updater, sel_mux_tos;

  stack_ctrl_sequencer #(
    .ADDR_WIDTH (AW),
    .STACK_DEPTH(FULL)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_op              (req_op),
    .req_src             (req_src),
    .tos_restore         (tos_restore),
    .req_ready           (req_ready),
    .done                (done),
    .err_overflow        (err_overflow),
    .err_underflow       (err_underflow),
    .depth               (depth),
    .sel_mux_stack       (sel_mux_stack),
    .ctrl_reg_write_stack(ctrl_reg_write_stack),
    .ctrl_stack          (ctrl_stack),
    .ctrl_reg_read_stack (ctrl_reg_read_stack),
    .ctrl_reg_read_mem   (ctrl_reg_read_mem),
    .ctrl_reg_write_mem  (ctrl_reg_write_mem),
    .ctrl_mem_ext        (ctrl_mem_ext),
    .ctrl_reg_tos        (ctrl_reg_tos),
    .sel_tos_updater     (sel_tos_updater),
    .sel_mux_tos         (sel_mux_tos)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;
  int   acc_cyc = 0;
  int   last_lat = -1;
  int   last_eo = 0;
  int   last_eu = 0;
  int   depth_m = 0;
  ent_t plan[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input out_t o, input int d);
    ent_t e;
    e.o = o;
    e.d = d;
    plan.push_back(e);
  endtask

  // Expected output sequence for one accepted request, from the request rules alone.
  task automatic build(input logic [2:0] op, input logic [2:0] src, input int tr);
    out_t z, w;
    int   d;
    logic [2:0] s;
    d = depth_m;
    z = '0;
    w = z;
    case (op)
      3'd0, 3'd2: begin
        if (d == FULL) begin
          add(z, d);
          w.dn = 1'b1; w.eo = 1'b1; add(w, d);
        end else begin
          s = (op == 3'd2) ? 3'b001 : src;
          if (op == 3'd2) begin
            add(z, d);
            w = z; w.rmem = 1'b1; add(w, d);
          end
          w = z; w.sel = s; w.wstk = 1'b1; add(w, d);
          w = z; w.sel = s; w.stk = 1'b1;  add(w, d);
          w = z; w.sel = s; w.tos = 1'b1; w.upd = 1'b1; add(w, d);
          d = d + 1;
          w = z; w.dn = 1'b1; add(w, d);
        end
      end
      3'd1, 3'd3: begin
        if (d == 0) begin
          add(z, d);
          w.dn = 1'b1; w.eu = 1'b1; add(w, d);
        end else begin
          w = z; w.tos = 1'b1; add(w, d);
          d = d - 1;
          add(z, d);
          w = z; w.rstk = 1'b1; add(w, d);
          if (op == 3'd3) begin
            w = z; w.wmem = 1'b1; add(w, d);
            w = z; w.mext = 1'b1; add(w, d);
          end
          w = z; w.dn = 1'b1; add(w, d);
        end
      end
      3'd4: begin
        w = z; w.tos = 1'b1; w.mtos = 1'b1; add(w, d);
        d = (tr > FULL) ? FULL : tr;
        w = z; w.dn = 1'b1; add(w, d);
      end
      default: begin
        w = z; w.dn = 1'b1; add(w, d);
      end
    endcase
    depth_m = d;
  endtask

  // One clock cycle: compare DUT against the model, then drive the next inputs.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [2:0] src,
                       input logic [AW-1:0] tr, input logic rst);
    out_t act, exp;
    int   dexp;
    @(negedge clk);
    ncyc++;
    exp = '0;
    exp.ready = 1'b1;
    dexp = depth_m;
    if (plan.size() > 0) begin
      exp  = plan[0].o;
      dexp = plan[0].d;
    end
    act = {req_ready, done, err_overflow, err_underflow, sel_mux_stack, ctrl_reg_write_stack,
           ctrl_stack, ctrl_reg_read_stack, ctrl_reg_read_mem, ctrl_reg_write_mem,
           ctrl_mem_ext, ctrl_reg_tos, sel_tos_updater, sel_mux_tos};
    total++;
    if (act !== exp || int'(depth) != dexp) begin
      bad++;
      $display("FAIL cycle %0d outputs: got %b depth %0d expected %b depth %0d",
               ncyc, act, depth, exp, dexp);
    end
    if (done) begin
      last_lat = ncyc - acc_cyc;
      last_eo  = int'(err_overflow);
      last_eu  = int'(err_underflow);
    end
    reset       = rst;
    req_valid   = v;
    req_op      = op;
    req_src     = src;
    tos_restore = tr;
    if (plan.size() > 0) void'(plan.pop_front());
    if (rst) begin
      plan.delete();
      depth_m = 0;
    end else if (exp.ready && v) begin
      acc_cyc  = ncyc;
      last_lat = -1;
      build(op, src, int'(tr));
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] src, input logic [AW-1:0] tr);
    int n;
    cycle(1'b1, op, src, tr, 1'b0);
    n = 0;
    while (plan.size() > 0 && n < 30) begin
      cycle(1'b0, 3'b000, 3'b000, '0, 1'b0);
      n++;
    end
    if (n >= 30) chk("req_timeout", n, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);

    req(3'd0, 3'b000, 4'd0);
    chk("push_lat", last_lat, 4);
    chk("push_depth", int'(depth), 1);
    req(3'd1, 3'b000, 4'd0);
    chk("pop_lat", last_lat, 4);
    chk("pop_depth", int'(depth), 0);
    req(3'd1, 3'b000, 4'd0);
    chk("unf_lat", last_lat, 2);
    chk("unf_flag", last_eu, 1);
    req(3'd4, 3'b000, 4'd15);
    chk("restore_sat", int'(depth), FULL);
    req(3'd2, 3'b101, 4'd0);
    chk("ovf_lat", last_lat, 2);
    chk("ovf_flag", last_eo, 1);
    chk("ovf_depth", int'(depth), FULL);
    req(3'd4, 3'b000, 4'd2);
    req(3'd3, 3'b000, 4'd0);
    chk("store_lat", last_lat, 6);
    chk("store_depth", int'(depth), 1);
    req(3'd2, 3'b110, 4'd0);
    chk("load_lat", last_lat, 6);
    req(3'd7, 3'b000, 4'd0);
    chk("nop_lat", last_lat, 1);
    req(3'd4, 3'b000, 4'd5);
    chk("restore_5", int'(depth), 5);
    // PUSH, then reset during its P_WR cycle.
    cycle(1'b1, 3'd0, 3'b011, '0, 1'b0);
    cycle(1'b0, 3'd0, 3'b000, '0, 1'b0);
    cycle(1'b0, 3'd0, 3'b000, '0, 1'b1);
    cycle(1'b0, 3'd0, 3'b000, '0, 1'b0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_no_done", int'(done), 0);

    for (int i = 0; i < 4000; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      cycle(($urandom_range(0, 2) != 0), op, 3'($urandom), 4'($urandom),
            ($urandom_range(0, 299) == 0));
    end
    cycle(1'b0, 3'd0, 3'b000, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
